// File: rtl/lsu_mem_port.sv
// Load/store unit: one data-memory access per core request over a
// valid/ready memory port, with byte/half/word lane steering, load
// extension and a response timeout.
// Optional build macro: LSU_MISALIGN_CHECK_EN (misaligned half/word accesses
// answer with an error and never reach memory).
module lsu_mem_port #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_legal;
  logic [1:0]        ld_off;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;
  logic [3:0]        st_mask;
  logic [31:0]       st_data;

  // Classify the incoming request: size/sign code and, optionally, alignment.
  always_comb begin
    req_legal = 1'b0;
    if (req_store) begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010);
    end else begin
      req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                  (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                  (req_funct3 == 3'b101);
    end
`ifdef LSU_MISALIGN_CHECK_EN
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])
      req_legal = 1'b0;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
      req_legal = 1'b0;
`endif
  end

  // Load extraction and store lane steering from the latched request.
  always_comb begin
    ld_off   = 2'b00;
    st_mask  = 4'b0000;
    st_data  = wdata_q;
    load_ext = '0;
    case (funct3_q[1:0])
      2'b00: begin
        ld_off  = addr_q[1:0];
        st_mask = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        ld_off  = {addr_q[1], 1'b0};
        st_mask = 4'b0011 << {addr_q[1], 1'b0};
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        ld_off  = 2'b00;
        st_mask = 4'b1111;
        st_data = wdata_q;
      end
    endcase
    shifted = mem_rdata >> {ld_off, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Next-state logic for the request/response sequencer.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_legal) begin
            state_d = S_REQ;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp_valid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = store_q ? '0 : load_ext;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_we        = mem_req_valid && store_q;
  assign mem_wmask     = mem_we ? st_mask : 4'b0000;
  assign mem_wdata     = mem_we ? st_data : '0;
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_valid ? rdata_q : '0;
  assign resp_err      = resp_valid && err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a response scoreboard.
module tb_lsu_mem_port;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb_q[$];   // {rdata, err}

  lsu_mem_port #(.ADDR_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, consume it.
  task automatic wait_resp(input int budget);
    int n = 0;
    logic [32:0] e;
    while (!resp_valid && n < budget) begin
      tick();
      n++;
    end
    chk("resp_arrives", {31'h0, resp_valid}, 32'h1);
    if (resp_valid) begin
      chk("sb_nonempty", {31'h0, sb_q.size() != 0}, 32'h1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("resp_rdata", resp_rdata, e[32:1]);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e[0]});
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("back_idle", {31'h0, req_ready}, 32'h1);
    end
  endtask

  // Legal access with zero memory stall: checks port fields and minimum latency.
  task automatic do_acc(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input logic [3:0] emask, input logic [31:0] ewd,
                        input logic [31:0] er);
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    sb_q.push_back({er, 1'b0});
    tick();                                   // cycle 1: REQ
    req_valid = 1'b0;
    chk("mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    chk("mem_we", {31'h0, mem_we}, {31'h0, st});
    chk("mem_wmask", {28'h0, mem_wmask}, {28'h0, emask});
    if (st) chk("mem_wdata", mem_wdata, ewd);
    mem_req_ready = 1'b1;
    tick();                                   // cycle 2: WAIT
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = rd;
    chk("no_early_resp", {31'h0, resp_valid}, 32'h0);
    tick();                                   // cycle 3: RESP
    mem_resp_valid = 1'b0;
    chk("latency3", {31'h0, resp_valid}, 32'h1);
    wait_resp(1);
  endtask

  task automatic do_illegal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = 32'h1111_2222;
    sb_q.push_back({32'h0, 1'b1});
    tick();
    req_valid = 1'b0;
    chk("illegal_no_mem", {31'h0, mem_req_valid}, 32'h0);
    chk("illegal_resp_now", {31'h0, resp_valid}, 32'h1);
    wait_resp(1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Sign/zero extension and lane steering.
    do_acc(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 4'b0000, 32'h0, 32'hFFFF_FF80);
    do_acc(1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_acc(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    do_acc(1'b1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0, 4'b1111, 32'h1234_5678, 32'h0);
    do_acc(1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 4'b0000, 32'h0, 32'hFFFF_8001);
    do_acc(1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_AB00, 4'b0000, 32'h0, 32'h0000_00AB);
    do_acc(1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h1234_5678, 4'b0000, 32'h0, 32'h1234_5678);
    do_acc(1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 4'b0000, 32'h0, 32'h0000_007F);

    // LHU with a stalled memory request and a stalled response consumer.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b101; req_addr = 32'h10;
    sb_q.push_back({32'h0000_1234, 1'b0});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
      chk("stall_mem_addr", mem_addr, 32'h10);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("stall_end_valid", {31'h0, mem_req_valid}, 32'h1);
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h5678_1234;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      chk("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("hold_resp_rdata", resp_rdata, 32'h0000_1234);
      tick();
    end
    wait_resp(1);

    // Timeout: no memory response after the request handshake.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    sb_q.push_back({32'h0, 1'b1});
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      chk("to_waiting", {31'h0, resp_valid}, 32'h0);
      tick();
    end
    chk("to_resp_valid", {31'h0, resp_valid}, 32'h1);
    wait_resp(1);
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_0000;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray_ignored_resp", {31'h0, resp_valid}, 32'h0);
    chk("stray_ignored_ready", {31'h0, req_ready}, 32'h1);
    chk("stray_ignored_mem", {31'h0, mem_req_valid}, 32'h0);

    // Illegal size codes.
    do_illegal(1'b0, 3'b011, 32'h0000_0040);
    do_illegal(1'b1, 3'b100, 32'h0000_0040);
`ifdef LSU_MISALIGN_CHECK_EN
    do_illegal(1'b0, 3'b010, 32'h0000_0002);
    do_illegal(1'b0, 3'b001, 32'h0000_0001);
`else
    do_acc(1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'hCAFE_F00D, 4'b0000, 32'h0, 32'hCAFE_F00D);
`endif

    // Reset while waiting on memory abandons the access.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rstw_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstw_still_idle", {31'h0, resp_valid}, 32'h0);
    do_acc(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 4'b0000, 32'h0, 32'h0BAD_CAFE);

    chk("sb_drained", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit that takes the ALU result as the effective address and performs one data-memory access per request over a valid/ready memory port.
- Sits between the execute stage and data memory.
- Replaces the single-cycle combinational memory path so that multi-cycle memories and buses can be used.
- Handles byte/half/word sizing, write masks, load sign/zero extension and response timeout.

Parameters:
- ADDR_W, 32, effective address width; mem_addr width.
- TIMEOUT_CYC, 255, max cycles in WAIT before error response; 0 disables timeout.
- CNT_W, 8, timeout counter width; must satisfy TIMEOUT_CYC < 2**CNT_W.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents an access
- req_ready  output  1  LSU can accept; 1 only in IDLE
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 size/sign code
- req_addr  input  ADDR_W  effective address (ALU result)
- req_wdata  input  32  store data (rs2)
- resp_valid  output  1  response available
- resp_ready  input  1  core consumes response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3, misaligned (optional feature) or timeout
- mem_req_valid  output  1  memory request
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2],2'b00}
- mem_we  output  1  write enable
- mem_wmask  output  4  byte lanes for stores; 0 for loads
- mem_wdata  output  32  lane-aligned store data
- mem_resp_valid  input  1  read data / write ack
- mem_rdata  input  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE; timeout counter 0; all outputs 0 except req_ready=1. Reset mid-transaction abandons the transaction; no response is issued.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch store, funct3, addr, wdata. If the request is legal, go to REQ; otherwise go to RESP with err=1 and no memory access.
  - REQ: mem_req_valid=1; address, we, wmask and wdata are stable until mem_req_ready. On handshake, go to WAIT with counter cleared.
  - WAIT: counter increments each cycle. On mem_resp_valid, capture the result and go to RESP with err=0. mem_resp_valid takes priority over timeout when both occur in the same cycle. If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 without mem_resp_valid, go to RESP with err=1 and rdata=0.
  - RESP: resp_valid=1; rdata and err held stable until resp_ready. On resp_ready, go to IDLE.
- mem_resp_valid outside WAIT is ignored.
- Minimum latency: accept in cycle 0, mem_req_valid in cycle 1, resp_valid in cycle 3 when mem_req_ready=1 in cycle 1 and mem_resp_valid=1 in cycle 2.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Store lanes, with off = addr[1:0]:
  - SB: wmask = 4'b0001<<off; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011<<{addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111; wdata unchanged.
  - Store resp_rdata = 0.
- Load extraction: shifted = mem_rdata >> (8*off).
  - LB / LBU: sign / zero extend shifted[7:0].
  - LH / LHU: sign / zero extend shifted[15:0], using off = {addr[1],0}.
  - LW: shifted with off = 0.
- Address beyond ADDR_W bits is not checked.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A halfword access with addr[0]=1 is illegal.
  - A word access with addr[1:0]!=0 is illegal.
  - Illegal accesses produce an err=1 response with no memory request.
- Undefined:
  - Misalignment is never flagged.
  - Halfword ignores addr[0]; word ignores addr[1:0]; mask and extraction follow the rules above.

Test Plan:
- LB at addr 0x8000_0003, mem_rdata=0x80FF_1234 -> mem_addr 0x8000_0000, wmask 0, resp_rdata 0xFFFF_FF80, err 0, resp_valid at cycle 3.
- SH at addr 0x0000_0102, wdata 0xDEAD_BEEF -> mem_we 1, wmask 4'b1100, mem_wdata 0xBEEF_BEEF, resp_rdata 0 after ack.
- LHU at 0x10, mem_req_ready low for 4 cycles, then resp_ready low for 3 cycles -> mem_req_valid/mem_addr stable throughout stall; resp_rdata 0x0000_1234 for mem_rdata 0x5678_1234, held until resp_ready.
- TIMEOUT_CYC=4, LW with no mem_resp_valid -> resp_valid with err 1, rdata 0, 4 cycles after REQ handshake; a mem_resp_valid arriving afterward in IDLE is ignored.
- funct3=011 load -> no mem_req_valid, err 1. With LSU_MISALIGN_CHECK_EN, LW at 0x2 -> err 1 and no mem request; without it -> normal access at mem_addr 0x0.
- rst_n pulsed low while in WAIT -> immediate IDLE, resp_valid 0, req_ready 1; a new LW then completes normally.
